// File: rtl/irda_pkg.sv
// Shared constants for the fishbowl IR link. The transmitter and the receiver both take their
// bit period and payload width from here, so the two ends always agree on the frame format.
package irda_pkg;

  localparam int unsigned IRDA_DIV    = 50;
  localparam int unsigned IRDA_DATA_W = 4;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

endpackage

// File: rtl/irda_sync.sv
// Two-flop synchroniser plus a previous-level flop for an asynchronous input.
// Emits the clean level and a single-cycle rising-edge pulse.
module irda_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic       s1_q, s2_q, prev_q, armed_q;
  logic [1:0] fill_q;

  // A rise only counts once the line has been seen low after reset, so a line that is already
  // high when reset releases does not look like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      s1_q   <= async_in;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      fill_q <= {fill_q[0], 1'b1};
      if (fill_q[1] && !s2_q) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~prev_q & armed_q;

endmodule

// File: rtl/irda_in.sv
// IR receive front end: finds the start edge, samples each bit at mid-bit, checks the start and
// stop bits and presents the decoded command with a one-cycle valid or error pulse.
module irda_in
  import irda_pkg::*;
#(
  parameter int unsigned DIV    = IRDA_DIV,
  parameter int unsigned DATA_W = IRDA_DATA_W,
  parameter int unsigned CNT_W  = $clog2(DIV)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Irx,
  output logic [DATA_W-1:0] Oout,
  output logic              Oout_vld,
  output logic              Oerr
);

  localparam int unsigned      Cnt1W   = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] HalfM1  = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DIV - 1);
  localparam logic [Cnt1W-1:0] LastBit = Cnt1W'(DATA_W - 1);

  logic              level, rise;
  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d;
  logic [Cnt1W-1:0]  cnt1_q, cnt1_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              vld_q, vld_d;
  logic              err_q, err_d;

  irda_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (Irx),
    .level    (level),
    .rise     (rise)
  );

  always_comb begin
    state_d = state_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    shift_d = shift_q;
    out_d   = out_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (rise) begin
          state_d = StStart;
          cnt0_d  = '0;
        end
      end
      StStart: begin
        if (cnt0_q == HalfM1) begin
          cnt0_d  = '0;
          cnt1_d  = '0;
          // A start bit that has gone low by mid-bit was a glitch; drop it silently.
          state_d = level ? StData : StIdle;
        end else begin
          cnt0_d = cnt0_q + 1'b1;
        end
      end
      StData: begin
        if (cnt0_q == LastCnt) begin
          cnt0_d  = '0;
          // LSB first: shifting in at the top leaves bit 0 at the bottom after DATA_W samples.
          shift_d = {level, shift_q[DATA_W-1:1]};
          if (cnt1_q == LastBit) begin
            state_d = StStop;
          end else begin
            cnt1_d = cnt1_q + 1'b1;
          end
        end else begin
          cnt0_d = cnt0_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt0_q == LastCnt) begin
          cnt0_d  = '0;
          state_d = StIdle;
          if (!level) begin
            vld_d = 1'b1;
            out_d = shift_q;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt0_d = cnt0_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      shift_q <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      shift_q <= shift_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign Oout     = out_q;
  assign Oout_vld = vld_q;
  assign Oerr     = err_q;

endmodule

// File: tb/tb_irda_in.sv
// Directed bench for irda_in: drives frames bit by bit and scoreboards every valid/error pulse
// against its expected kind, data and cycle of arrival.
module tb_irda_in;
  import irda_pkg::*;

  localparam int unsigned DIV     = 50;
  localparam int          LATENCY = 2 + DIV / 2 + 5 * DIV + 1;

  typedef struct {
    logic       is_err;
    logic [3:0] data;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       Irx = 1'b0;
  logic [3:0] Oout;
  logic       Oout_vld;
  logic       Oerr;

  int         cyc = 0;
  int         passed = 0;
  int         total = 0;
  exp_t       sb_q[$];
  logic [3:0] last_good = 4'h0;

  irda_in #(
    .DIV    (DIV),
    .DATA_W (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Irx      (Irx),
    .Oout     (Oout),
    .Oout_vld (Oout_vld),
    .Oerr     (Oerr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Scoreboard: every output pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (Oout_vld || Oerr) begin
      check("vld_err_exclusive", {31'd0, Oout_vld & Oerr}, 32'd0);
      check("pulse_expected", {31'd0, sb_q.size() != 0}, 32'd1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("pulse_kind_err", {31'd0, Oerr}, {31'd0, e.is_err});
        check("pulse_data", {28'd0, Oout}, {28'd0, e.data});
        check("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  // Caller must be at a negedge. Slots: start, d0..d3, stop; only the first nbits are driven.
  task automatic send_frame(input logic [3:0] d, input logic stop, input int nbits);
    logic [5:0] bits;
    exp_t       e;
    bits = {stop, d, 1'b1};
    if (nbits == 6) begin
      e.is_err = stop;
      e.data   = stop ? last_good : d;
      e.cyc    = cyc + LATENCY;
      sb_q.push_back(e);
      if (!stop) last_good = d;
    end
    for (int i = 0; i < nbits; i++) begin
      Irx = bits[i];
      repeat (DIV) @(negedge clk);
    end
    if (nbits == 6) Irx = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 8 * DIV; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    check(tag, sb_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_oout", {28'd0, Oout}, 32'd0);
    check("reset_vld", {31'd0, Oout_vld}, 32'd0);
    check("reset_err", {31'd0, Oerr}, 32'd0);
    rst_n = 1'b1;

    // Quiet line: any pulse here is flagged by the scoreboard.
    repeat (1000) @(negedge clk);
    check("idle_oout", {28'd0, Oout}, 32'd0);

    send_frame(4'h6, 1'b0, 6);
    wait_drain("drain_frame6");
    check("hold_after_6", {28'd0, Oout}, 32'h6);

    // Back-to-back frames.
    send_frame(4'hA, 1'b0, 6);
    send_frame(4'h5, 1'b0, 6);
    wait_drain("drain_a5");

    // 10-clock glitch, then a frame once the receiver has dropped back to idle.
    Irx = 1'b1;
    repeat (10) @(negedge clk);
    Irx = 1'b0;
    repeat (30) @(negedge clk);
    check("glitch_state_idle", {30'd0, dut.state_q}, {30'd0, StIdle});
    send_frame(4'h9, 1'b0, 6);
    wait_drain("drain_after_glitch");

    // Bad stop bit: error pulse, command unchanged.
    send_frame(4'hC, 1'b1, 6);
    wait_drain("drain_bad_stop");
    check("oout_kept_after_err", {28'd0, Oout}, 32'h9);

    // Reset in the middle of data bit 2 of a 4'hF frame.
    send_frame(4'hF, 1'b0, 3);
    Irx = 1'b1;
    repeat (DIV / 2) @(negedge clk);
    rst_n = 1'b0;
    Irx   = 1'b0;
    @(negedge clk);
    check("midrst_oout", {28'd0, Oout}, 32'd0);
    check("midrst_vld", {31'd0, Oout_vld}, 32'd0);
    check("midrst_err", {31'd0, Oerr}, 32'd0);
    check("midrst_state", {30'd0, dut.state_q}, {30'd0, StIdle});
    last_good = 4'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(4'h3, 1'b0, 6);
    wait_drain("drain_after_reset");

    // Line stuck high across reset release must not start a frame.
    rst_n = 1'b0;
    Irx   = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8 * DIV) @(negedge clk);
    check("stuck_high_state", {30'd0, dut.state_q}, {30'd0, StIdle});
    last_good = 4'h0;
    Irx = 1'b0;
    repeat (20) @(negedge clk);
    send_frame(4'h7, 1'b0, 6);
    wait_drain("drain_after_stuck");
    check("final_oout", {28'd0, Oout}, 32'h7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/irda_in.md
Name: irda_in

Overview:
- IR receive front end for the fishbowl remote-control link.
- Consumes the serial line produced by the button-side transmitter. Line format:
  - Idle low.
  - Start bit 1.
  - 4 data bits, LSB first.
  - Stop bit 0.
  - Each bit is DIV clocks wide.
- Synchronises and edge-detects the line, samples each bit at mid-bit, checks start/stop, and presents the decoded 4-bit command with a one-cycle valid pulse to the tank control logic.

Parameters:
- DIV, 50, clocks per bit; must equal the transmitter's DIV; legal range >= 4.
- DATA_W, 4, number of data bits per frame.
- CNT_W, $clog2(DIV), width of the bit-period counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous reset, active low.
- Irx  input  1  raw IR line, asynchronous to clk.
- Oout  output  DATA_W  last correctly received command.
- Oout_vld  output  1  one-cycle pulse: Oout updated this cycle.
- Oerr  output  1  one-cycle pulse: frame rejected (bad stop bit).

Behaviour:
- Clock and reset:
  - Single clock clk.
  - rst_n asynchronous assert, active low; all flops reset.
  - Reset values: Oout=0, Oout_vld=0, Oerr=0, state=IDLE, counters=0, sync flops=0.
- Input conditioning:
  - Irx passes through a 2-flop synchroniser, then a third flop holds the previous level.
  - Rising edge E = the cycle with sync level 1 and previous level 0.
- State machine IDLE / START / DATA / STOP:
  - IDLE: on E, go to START with cnt0=0 in cycle E+1. Any other line activity is ignored; a line stuck high at reset release does not start a frame.
  - START:
    - cnt0 increments each clock.
    - At cnt0==DIV/2-1 (floor), the start bit is sampled.
    - Sampled 1: go to DATA, cnt0=0, bit index cnt1=0.
    - Sampled 0: glitch; return to IDLE silently (no Oerr).
  - DATA:
    - At each cnt0==DIV-1, sample the line into shift bit cnt1 (LSB first) and clear cnt0.
    - After sampling bit DATA_W-1, go to STOP with cnt0=0.
  - STOP: at cnt0==DIV-1, sample the line.
    - Sampled 0: next cycle Oout<=shift register, Oout_vld=1 for exactly one cycle.
    - Sampled 1: next cycle Oerr=1 for one cycle; Oout unchanged.
    - Either way, return to IDLE.
- Exact timing relative to E:
  - Start-bit sample at E+DIV/2.
  - Data bit k (k=0..3) sampled at E+DIV/2+(k+1)*DIV.
  - Stop-bit sample at E+DIV/2+5*DIV.
  - Oout/Oout_vld/Oerr asserted in cycle E+DIV/2+5*DIV+1 (E+276 for DIV=50).
- Oout holds its value between valid frames; Oout_vld and Oerr are never high in the same cycle.
- Line activity while not in IDLE (including a new rising edge) is ignored until return to IDLE.
- Back-to-back frames:
  - The transmitter stop bit (0) lasts DIV clocks.
  - The receiver is back in IDLE by mid-stop-bit, so the next start edge is always caught.
- Reset asserted mid-frame: immediate abort; no Oout_vld/Oerr is generated for the partial frame.
- Counter arithmetic: cnt0 is CNT_W bits and never exceeds DIV-1; cnt1 is $clog2(DATA_W+1) bits.

Decomposition:
- Shared package irda_pkg holds:
  - State encoding enum (IDLE, START, DATA, STOP).
  - Default DIV and DATA_W constants.
  - Both irda_in and the transmitter take DIV/DATA_W from irda_pkg so the bit period cannot diverge.
- One sub-module, irda_sync:
  - 2-flop synchroniser plus previous-level flop.
  - Outputs a clean level and a rise pulse.
  - Reusable for other asynchronous sensor inputs.

Test Plan:
- Idle line held 0 for 1000 clocks after reset -> Oout=0, Oout_vld and Oerr never asserted.
- Drive frame 1,0,1,1,0,0 (start, data 4'b0110 LSB-first, stop), DIV=50 per bit -> Oout=4'h6 with a single Oout_vld pulse at E+276.
- Loopback with the transmitter: send Iin=4'hA then 4'h5 back-to-back -> two Oout_vld pulses, Oout=4'hA then 4'h5, no Oerr.
- 10-clock high glitch on Irx while IDLE -> returns to IDLE at start sample; no Oout_vld, no Oerr; a valid frame sent immediately afterwards decodes correctly.
- Frame with stop bit forced to 1 -> Oerr single pulse at E+276; Oout retains its previous value.
- Assert rst_n low at mid data bit 2 of a frame carrying 4'hF, release -> all outputs 0, state IDLE; a following 4'h3 frame yields Oout=4'h3.
